// File: rtl/lift_pkg.sv
// Shared lift definitions: floor sizing and scheduler state encoding.
// Also imported by the lift state controller.
package lift_pkg;

  localparam int unsigned N_FLOORS = 4;
  localparam int unsigned FLOOR_W  = 2;
  localparam int unsigned STATE_W  = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_DOOR     = 3'd1;
  localparam logic [STATE_W-1:0] ST_MOVE     = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_RUN = 3'd3;
  localparam logic [STATE_W-1:0] ST_ARRIVE   = 3'd4;

endpackage

// File: rtl/lift_call_scheduler_call_latch.sv
// Pending-call register with set/clear-by-index, plus here/ahead/behind
// reductions relative to the current floor and sweep direction.
module call_latch
  import lift_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  input  logic [N_FLOORS-1:0] i_set,
  input  logic                i_clr_en,
  input  logic [FLOOR_W-1:0]  i_clr_idx,
  input  logic [FLOOR_W-1:0]  i_cur_floor,
  input  logic                i_dir_up,
  output logic [N_FLOORS-1:0] o_pending,
  output logic                o_here_c,
  output logic                o_ahead_c,
  output logic                o_behind_c,
  output logic                o_any_c
);

  logic [N_FLOORS-1:0] r_pending;
  logic [N_FLOORS-1:0] w_pending_nxt;
  logic [N_FLOORS-1:0] w_above;
  logic [N_FLOORS-1:0] w_below;

  // Clear wins over a same-cycle set: the stop in progress serves that call.
  always_comb begin
    w_pending_nxt = r_pending | i_set;
    if (i_clr_en) w_pending_nxt[i_clr_idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_pending <= '0;
    else     r_pending <= w_pending_nxt;
  end

  always_comb begin
    w_above = '0;
    w_below = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (FLOOR_W'(i) > i_cur_floor) w_above[i] = r_pending[i];
      if (FLOOR_W'(i) < i_cur_floor) w_below[i] = r_pending[i];
    end
  end

  assign o_pending  = r_pending;
  assign o_here_c   = r_pending[i_cur_floor];
  assign o_ahead_c  = i_dir_up ? (|w_above) : (|w_below);
  assign o_behind_c = i_dir_up ? (|w_below) : (|w_above);
  assign o_any_c    = |r_pending;

endmodule

// File: rtl/lift_call_scheduler.sv
// SCAN-style call scheduler for the 4-floor lift: latches calls, issues
// one-floor moves and door holds. Optional return-home via LIFT_IDLE_HOME_EN.
module lift_call_scheduler
  import lift_pkg::*;
#(
  parameter int unsigned DOOR_CYCLES = 8,
  parameter int unsigned IDLE_CYCLES = 64
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]  cur_floor,
  input  logic                lift_run,
  output logic                go_up,
  output logic                go_down,
  output logic                open_door,
  output logic                dir_up,
  output logic [N_FLOORS-1:0] pending,
  output logic                busy
);

  localparam int unsigned DOOR_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);

  logic [STATE_W-1:0] r_state, w_state_nxt;
  logic               r_dir_up, w_dir_nxt;
  logic [DOOR_W-1:0]  r_door_cnt, w_door_cnt_nxt;
  logic [FLOOR_W-1:0] r_start, w_start_nxt;
  logic               r_go_up, r_go_down, r_open_door, r_busy;
  logic               w_go_up_nxt, w_go_down_nxt;
  logic               w_clr_en;
  logic               w_here, w_ahead, w_behind, w_any;

`ifdef LIFT_IDLE_HOME_EN
  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
  logic              r_homing, w_homing_nxt;
  logic [IDLE_W-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic              w_idle_fire;
`else
  logic w_unused_idle_cfg;
  assign w_unused_idle_cfg = (IDLE_CYCLES != 0);
`endif

  call_latch u_call_latch (
    .clk         (clk),
    .clr         (clr),
    .i_set       (call_req),
    .i_clr_en    (w_clr_en),
    .i_clr_idx   (cur_floor),
    .i_cur_floor (cur_floor),
    .i_dir_up    (r_dir_up),
    .o_pending   (pending),
    .o_here_c    (w_here),
    .o_ahead_c   (w_ahead),
    .o_behind_c  (w_behind),
    .o_any_c     (w_any)
  );

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_dir_nxt      = r_dir_up;
    w_door_cnt_nxt = r_door_cnt;
    w_start_nxt    = r_start;
`ifdef LIFT_IDLE_HOME_EN
    w_homing_nxt   = r_homing;
    w_idle_cnt_nxt = '0;
    w_idle_fire    = (r_idle_cnt == IDLE_W'(IDLE_CYCLES - 1));
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_here) begin
          w_state_nxt = ST_DOOR;
        end else if (w_ahead) begin
          w_state_nxt = ST_MOVE;
        end else if (w_behind) begin
          w_dir_nxt   = ~r_dir_up;
          w_state_nxt = ST_MOVE;
        end
`ifdef LIFT_IDLE_HOME_EN
        else if (cur_floor != '0) begin
          if (w_idle_fire) begin
            w_dir_nxt    = 1'b0;
            w_homing_nxt = 1'b1;
            w_state_nxt  = ST_MOVE;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + IDLE_W'(1);
          end
        end
`endif
      end
      ST_DOOR: begin
        // A new call at this floor keeps the door open for a full period.
        if (call_req[cur_floor]) begin
          w_door_cnt_nxt = '0;
        end else if (r_door_cnt == DOOR_W'(DOOR_CYCLES - 1)) begin
          if (w_ahead) begin
            w_state_nxt = ST_MOVE;
          end else if (w_any) begin
            w_dir_nxt   = ~r_dir_up;
            w_state_nxt = ST_MOVE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_door_cnt_nxt = r_door_cnt + DOOR_W'(1);
        end
      end
      ST_MOVE: begin
        w_start_nxt = cur_floor;
        w_state_nxt = ST_WAIT_RUN;
      end
      ST_WAIT_RUN: begin
        if (lift_run) w_state_nxt = ST_ARRIVE;
      end
      ST_ARRIVE: begin
        if (!lift_run && (cur_floor != r_start)) begin
          if (w_here)       w_state_nxt = ST_DOOR;
          else if (w_ahead) w_state_nxt = ST_MOVE;
`ifdef LIFT_IDLE_HOME_EN
          else if (r_homing && (cur_floor != '0)) w_state_nxt = ST_MOVE;
`endif
          else              w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_state_nxt != ST_DOOR) w_door_cnt_nxt = '0;
`ifdef LIFT_IDLE_HOME_EN
    if (w_any || (call_req != '0) || (w_state_nxt == ST_IDLE)) w_homing_nxt = 1'b0;
`endif

    w_clr_en      = (w_state_nxt == ST_DOOR);
    // Direction is forced at the end floors, so these guards never suppress a legal move.
    w_go_up_nxt   = (w_state_nxt == ST_MOVE) && w_dir_nxt && (cur_floor != TOP_FLOOR);
    w_go_down_nxt = (w_state_nxt == ST_MOVE) && !w_dir_nxt && (cur_floor != '0);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= ST_IDLE;
      r_dir_up    <= 1'b1;
      r_door_cnt  <= '0;
      r_start     <= '0;
      r_go_up     <= 1'b0;
      r_go_down   <= 1'b0;
      r_open_door <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dir_up    <= w_dir_nxt;
      r_door_cnt  <= w_door_cnt_nxt;
      r_start     <= w_start_nxt;
      r_go_up     <= w_go_up_nxt;
      r_go_down   <= w_go_down_nxt;
      r_open_door <= (w_state_nxt == ST_DOOR);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

`ifdef LIFT_IDLE_HOME_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_homing   <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_homing   <= w_homing_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end
`endif

  assign go_up     = r_go_up;
  assign go_down   = r_go_down;
  assign open_door = r_open_door;
  assign dir_up    = r_dir_up;
  assign busy      = r_busy;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler with a behavioural lift controller
// and an expected-event queue for move pulses and door stops.
module tb_lift_call_scheduler;

  typedef struct packed {
    logic [1:0] kind;   // 0 = up pulse, 1 = down pulse, 2 = door stop
    logic [1:0] floor;
    logic [7:0] len;    // expected door-open cycles
  } ev_t;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] call_req;
  logic       go_up, go_down, open_door, dir_up, busy;
  logic [3:0] pending;

  logic [1:0] init_floor = 2'd0;
  logic [1:0] m_floor;
  logic       m_run, m_dir;
  logic [3:0] m_tmr;

  ev_t sb_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  always #5 clk = ~clk;

  lift_call_scheduler dut (
    .clk       (clk),
    .clr       (clr),
    .call_req  (call_req),
    .cur_floor (m_floor),
    .lift_run  (m_run),
    .go_up     (go_up),
    .go_down   (go_down),
    .open_door (open_door),
    .dir_up    (dir_up),
    .pending   (pending),
    .busy      (busy)
  );

  // Lift controller: run rises two cycles after a move pulse, floor steps later.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_floor <= init_floor;
      m_run   <= 1'b0;
      m_tmr   <= 4'd0;
      m_dir   <= 1'b0;
    end else if (go_up || go_down) begin
      m_dir <= go_up;
      m_tmr <= 4'd6;
    end else if (m_tmr != 4'd0) begin
      m_tmr <= m_tmr - 4'd1;
      if (m_tmr == 4'd5) m_run <= 1'b1;
      if (m_tmr == 4'd2) begin
        m_floor <= m_dir ? m_floor + 2'd1 : m_floor - 2'd1;
        m_run   <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_ev(input logic [1:0] k, input logic [1:0] f, input logic [7:0] l);
    ev_t e;
    e.kind = k; e.floor = f; e.len = l;
    sb_q.push_back(e);
  endtask

  // Monitor: pops the queue on each move pulse and door opening.
  logic       door_prev = 1'b0;
  int         door_len = 0;
  logic [7:0] door_exp_len = 8'd0;
  always @(negedge clk) begin
    ev_t e;
    if (clr) begin
      door_prev = 1'b0;
      door_len  = 0;
    end else begin
      if (go_up || go_down) begin
        check("go_exclusive", 32'(go_up & go_down), 32'd0);
        if (sb_q.size() == 0) check("go_unexpected", 32'({go_up, go_down}), 32'd0);
        else begin
          e = sb_q.pop_front();
          check("go_event", 32'({(go_down ? 2'd1 : 2'd0), m_floor}), 32'({e.kind, e.floor}));
        end
      end
      if (open_door && !door_prev) begin
        if (sb_q.size() == 0) begin
          check("door_unexpected", 32'(open_door), 32'd0);
          door_exp_len = 8'd0;
        end else begin
          e = sb_q.pop_front();
          check("door_event", 32'({2'd2, m_floor}), 32'({e.kind, e.floor}));
          door_exp_len = e.len;
        end
        door_len = 1;
      end else if (open_door) begin
        door_len++;
      end
      if (!open_door && door_prev) check("door_len", 32'(door_len), 32'(door_exp_len));
      door_prev = open_door;
    end
  end

  task automatic pulse_call(input logic [3:0] v);
    call_req = v;
    @(negedge clk);
    call_req = 4'd0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle(input string tag);
    int n = 0;
    while ((busy || sb_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 400), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int busy_cnt;
    clr      = 1'b1;
    call_req = 4'd0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    check("rst_go_up", 32'(go_up), 32'd0);
    check("rst_go_down", 32'(go_down), 32'd0);
    check("rst_open_door", 32'(open_door), 32'd0);
    check("rst_dir_up", 32'(dir_up), 32'd1);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    busy_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || go_up || go_down || open_door) busy_cnt++;
    end
    check("idle_quiet", 32'(busy_cnt), 32'd0);

    // Floor 0 -> call on floor 2: two up moves then an 8-cycle door stop.
    push_ev(2'd0, 2'd0, 8'd0);
    push_ev(2'd0, 2'd1, 8'd0);
    push_ev(2'd2, 2'd2, 8'd8);
    pulse_call(4'b0100);
    check("pend_latch_2", 32'(pending), 32'h4);
    settle("settle_up2");
    check("up2_pending", 32'(pending), 32'd0);
    check("up2_floor", 32'(m_floor), 32'd2);
    check("up2_dir", 32'(dir_up), 32'd1);

    // Floor 1 going up, calls on 0 and 3: serve 3 first, flip, then 0.
    init_floor = 2'd1;
    do_reset();
    push_ev(2'd0, 2'd1, 8'd0);
    push_ev(2'd0, 2'd2, 8'd0);
    push_ev(2'd2, 2'd3, 8'd8);
    push_ev(2'd1, 2'd3, 8'd0);
    push_ev(2'd1, 2'd2, 8'd0);
    push_ev(2'd1, 2'd1, 8'd0);
    push_ev(2'd2, 2'd0, 8'd8);
    pulse_call(4'b1001);
    check("pend_latch_9", 32'(pending), 32'h9);
    settle("settle_sweep");
    check("sweep_dir", 32'(dir_up), 32'd0);
    check("sweep_floor", 32'(m_floor), 32'd0);
    check("sweep_pending", 32'(pending), 32'd0);

    // Re-call at the open floor after 3 door cycles: 3 + 8 cycles open.
    push_ev(2'd2, 2'd0, 8'd11);
    pulse_call(4'b0001);
    k = 0;
    while (!open_door && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("door_rise", 32'(open_door), 32'd1);
    @(negedge clk);
    @(negedge clk);
    pulse_call(4'b0001);
    check("door_recall_clear", 32'(pending), 32'd0);
    check("door_recall_open", 32'(open_door), 32'd1);
    settle("settle_door");

    // clr while waiting for the lift to start: calls dropped, no pulse follows.
    push_ev(2'd0, 2'd0, 8'd0);
    pulse_call(4'b1000);
    k = 0;
    while (!go_up && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("clr_go_seen", 32'(go_up), 32'd1);
    @(negedge clk);
    check("clr_pre_pending", 32'(pending), 32'h8);
    check("clr_pre_busy", 32'(busy), 32'd1);
    init_floor = 2'd0;
    clr = 1'b1;
    #1;
    check("clr_pending", 32'(pending), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_go", 32'({go_up, go_down}), 32'd0);
    check("clr_dir", 32'(dir_up), 32'd1);
    @(negedge clk);
    clr = 1'b0;
    repeat (20) @(negedge clk);
    check("clr_post_queue", 32'(sb_q.size()), 32'd0);
    check("clr_post_busy", 32'(busy), 32'd0);
    check("clr_post_floor", 32'(m_floor), 32'd0);

`ifdef LIFT_IDLE_HOME_EN
    // Idle at floor 2: after the idle period, two down moves and no door.
    init_floor = 2'd2;
    do_reset();
    push_ev(2'd1, 2'd2, 8'd0);
    push_ev(2'd1, 2'd1, 8'd0);
    settle("settle_home");
    check("home_floor", 32'(m_floor), 32'd0);
    check("home_pending", 32'(pending), 32'd0);
    check("home_door", 32'(open_door), 32'd0);
`endif

    check("final_queue", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
